dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 width/sign codes,
// access-size decode helpers and the FSM state enumeration.
package dmem_pkg;

    // RV32I load/store width and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size as carried in funct3[1:0]; any other value behaves as a word
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Access size field of a funct3 code
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    // Loads extend with the sign bit unless funct3[2] selects the unsigned form
    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables / data replication and
// load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_wdata_c,
    output logic [31:0] o_rdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    // Select the addressed byte and half-word out of the stored word
    always_comb begin
        w_byte = i_rword[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        w_sext = f3_signed(i_funct3);
    end

    // Size decode: store lanes/data and extended load data
    always_comb begin
        o_be_c    = 4'b1111;
        o_wdata_c = i_wdata;
        o_rdata_c = i_rword;
        case (f3_size(i_funct3))
            SZ_B: begin
                o_be_c    = 4'b0001 << i_addr_lo;
                o_wdata_c = {4{i_wdata[7:0]}};
                o_rdata_c = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_wdata[15:0]}};
                o_rdata_c = {{16{w_sext & w_half[15]}}, w_half};
            end
            default: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_wdata;
                o_rdata_c = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory that answers one core load/store at a time after a
// fixed LATENCY wait. Optional misalignment trapping: DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned ADDR_W   = IDX_W + 2;
    localparam int unsigned CNT_W    = 4;
    localparam bit          ZERO_LAT = (LATENCY == 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                r_write;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;

    logic [31:0]         r_mem [DEPTH];

    logic                w_in_idle;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_write;
    logic [2:0]          w_funct3;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_rword;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_sh;
    logic [31:0]         w_rdata_ext;
    logic                w_misaligned;
    logic                w_do_store;
    logic                w_unused;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_accept  = req_valid & r_req_ready;

    // With zero latency the commit edge is the accept edge, so use live inputs in IDLE
    assign w_write  = w_in_idle ? req_write               : r_write;
    assign w_funct3 = w_in_idle ? req_funct3              : r_funct3;
    assign w_addr   = w_in_idle ? req_addr[ADDR_W-1:0]    : r_addr;
    assign w_wdata  = w_in_idle ? req_wdata               : r_wdata;
    assign w_idx    = w_addr[ADDR_W-1:2];
    assign w_rword  = r_mem[w_idx];

    // Address bits above the array are ignored, giving modulo DEPTH*4 wrap
    assign w_unused = &{1'b0, req_addr[31:ADDR_W]};

    dmem_lane_align u_lane_align (
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .i_rword   (w_rword),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata_sh),
        .o_rdata_c (w_rdata_ext)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    // Half-words must be 2-byte aligned and words 4-byte aligned
    always_comb begin
        w_misaligned = 1'b0;
        case (f3_size(w_funct3))
            SZ_B:    w_misaligned = 1'b0;
            SZ_H:    w_misaligned = w_addr[0];
            default: w_misaligned = |w_addr[1:0];
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // Next-state and wait-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (ZERO_LAT) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY);
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_enter_resp = (w_state_nxt == ST_RESP);
    assign w_do_store   = w_enter_resp & w_write & ~w_misaligned & ~rst;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W-1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Byte-enabled store commit; the array is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Registered handshake and response outputs, zeroed outside the response cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_enter_resp;
            r_rsp_err   <= w_enter_resp & w_misaligned;
            r_rsp_rdata <= (w_enter_resp & ~w_write & ~w_misaligned) ? w_rdata_ext : '0;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256, LATENCY=2).
// Expectations for misaligned accesses follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int errors;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One transaction; negedge k after the accept edge stands for edge k
    task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic noise,
                        output logic [31:0] rd, output logic er);
        int vk;
        int vcnt;
        int bad;
        vk = 0; vcnt = 0; bad = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        check({tag, ".ready0"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (noise) begin
                req_valid  = (k <= LAT);
                req_write  = 1'b1;
                req_funct3 = F3_W;
                req_addr   = 32'h40;
                req_wdata  = 32'h00000BAD;
            end
            if (req_ready !== (k == LAT + 2)) bad++;
            if (rsp_valid === 1'b1) begin
                vcnt++;
                vk = k;
                rd = rsp_rdata;
                er = rsp_err;
            end else if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
                bad++;
            end
        end
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        check({tag, ".rsp_edge"}, 32'(vk), 32'(LAT + 1));
        check({tag, ".rsp_cnt"}, 32'(vcnt), 32'd1);
        check({tag, ".idle_out"}, 32'(bad), 32'd0);
    endtask

    // Transaction plus data/error expectations
    task automatic run(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        xact(tag, w, f3, a, d, 1'b0, rd, er);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          vseen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

        // Reset state
        #1;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.err",   32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Word store, then sub-word loads of it
        run("sw10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        run("lb13",  1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        run("lbu13", 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        run("lh10",  1'b0, F3_H,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
        run("lhu12", 1'b0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
        run("lb10",  1'b0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
        run("lbu11", 1'b0, F3_BU, 32'h11, 32'h0,        32'h000000BE, 1'b0);
        run("lw10",  1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);

        // Byte and half stores merge into existing words
        run("sb11",  1'b1, F3_B,  32'h11, 32'h000000AA, 32'h0,        1'b0);
        run("lw10b", 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0);
        run("lw111", 1'b0, 3'b111, 32'h10, 32'h0,       32'hDEADAAEF, 1'b0);
        run("sw14",  1'b1, F3_W,  32'h14, 32'h0,        32'h0,        1'b0);
        run("sh16",  1'b1, F3_H,  32'h16, 32'h1234ABCD, 32'h0,        1'b0);
        run("lw14",  1'b0, F3_W,  32'h14, 32'h0,        32'hABCD0000, 1'b0);
        run("lh16",  1'b0, F3_H,  32'h16, 32'h0,        32'hFFFFABCD, 1'b0);
        run("sw18u", 1'b1, 3'b110, 32'h18, 32'h0F0F1234, 32'h0,       1'b0);
        run("lhu18", 1'b0, F3_HU, 32'h18, 32'h0,        32'h00001234, 1'b0);

        // Address wrap modulo DEPTH*4
        run("sw400", 1'b1, F3_W,  32'h400, 32'h12345678, 32'h0,       1'b0);
        run("lw000", 1'b0, F3_W,  32'h000, 32'h0,        32'h12345678, 1'b0);

        // Misaligned accesses
        run("sw20",  1'b1, F3_W,  32'h20, 32'h55555555, 32'h0,        1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        run("sw22",  1'b1, F3_W,  32'h22, 32'hCAFEF00D, 32'h0,        1'b1);
        run("lw20",  1'b0, F3_W,  32'h20, 32'h0,        32'h55555555, 1'b0);
        run("lh21",  1'b0, F3_H,  32'h21, 32'h0,        32'h0,        1'b1);
        run("lw23",  1'b0, F3_W,  32'h23, 32'h0,        32'h0,        1'b1);
`else
        run("sw22",  1'b1, F3_W,  32'h22, 32'hCAFEF00D, 32'h0,        1'b0);
        run("lw20",  1'b0, F3_W,  32'h20, 32'h0,        32'hCAFEF00D, 1'b0);
        run("lh21",  1'b0, F3_H,  32'h21, 32'h0,        32'hFFFFF00D, 1'b0);
        run("lw23",  1'b0, F3_W,  32'h23, 32'h0,        32'hCAFEF00D, 1'b0);
`endif

        // Requests presented while busy are ignored
        run("sw40",  1'b1, F3_W,  32'h40, 32'h11111111, 32'h0,        1'b0);
        xact("noise", 1'b1, F3_W, 32'h44, 32'h22222222, 1'b1, rd, er);
        run("lw40",  1'b0, F3_W,  32'h40, 32'h0,        32'h11111111, 1'b0);
        run("lw44",  1'b0, F3_W,  32'h44, 32'h0,        32'h22222222, 1'b0);

        // Reset during WAIT drops the store and the response
        run("sw30",  1'b1, F3_W,  32'h30, 32'h0BADF00D, 32'h0,        1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        check("midrst.busy", 32'(req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("midrst.ready", 32'(req_ready), 32'd1);
        check("midrst.valid", 32'(rsp_valid), 32'd0);
        check("midrst.rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vseen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) vseen++;
        end
        check("midrst.no_rsp", 32'(vseen), 32'd0);
        run("lw30",  1'b0, F3_W,  32'h30, 32'h0,        32'h0BADF00D, 1'b0);
        run("lw10c", 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
